// File: rtl/ad574_bus_ctrl_pkg.sv
// AD574 bus controller shared definitions.
// Op encodings, address bit positions, FSM states and pin bundle.
package ad574_bus_ctrl_pkg;

    localparam logic OP_READ = 1'b0;
    localparam logic OP_CONV = 1'b1;

    localparam int ADDR_A0   = 0;
    localparam int ADDR_12_8 = 1;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SETUP   = 3'd1,
        S_ACCESS  = 3'd2,
        S_HOLD    = 3'd3,
        S_STROBE  = 3'd4,
        S_WAIT    = 3'd5,
        S_RECOVER = 3'd6
    } state_e;

    typedef struct packed {
        logic cs_n;
        logic ce;
        logic rc;
        logic a0;
        logic b12;
        logic busy;
    } pins_t;

    localparam pins_t PINS_IDLE = '{
        cs_n: 1'b1, ce: 1'b0, rc: 1'b1,
        a0: 1'b0, b12: 1'b1, busy: 1'b0
    };

    function automatic int unsigned max_of(
        input int unsigned a,
        input int unsigned b
    );
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/ad574_sts_sync.sv
// Two-flop synchroniser for the asynchronous AD574 STS pin.
// Output is the input delayed by two clocks, reset to 0.
module ad574_sts_sync (
    input  logic clk,
    input  logic rstn,
    input  logic async_i,
    output logic sync_o
);

    logic meta_q;
    logic sync_q;

    // two-stage metastability filter
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= async_i;
            sync_q <= meta_q;
        end
    end

    assign sync_o = sync_q;

endmodule

// File: rtl/ad574_bus_ctrl.sv
// AD574 single-operation bus controller.
// Runs one start-conversion or read cycle per accepted request.
module ad574_bus_ctrl
    import ad574_bus_ctrl_pkg::*;
#(
    parameter int unsigned T_SU       = 2,
    parameter int unsigned T_CE       = 3,
    parameter int unsigned T_ACC      = 4,
    parameter int unsigned T_HLD      = 2,
    parameter int unsigned T_REC      = 2,
    parameter int unsigned T_STS_MIN  = 4,
    parameter int unsigned T_CONV_MAX = 4000
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        op_req,
    input  logic        op,
    input  logic [1:0]  addr,
    output logic        busy,
    output logic [11:0] rd_data,
    output logic        rd_valid,
    output logic        conv_done,
    output logic        err_tmo,
    output logic        ad_cs_n,
    output logic        ad_ce,
    output logic        ad_rc,
    output logic        ad_a0,
    output logic        ad_12_8,
    input  logic        ad_sts,
    input  logic [11:0] ad_data
);

    localparam int unsigned CNT_MAX =
        max_of(max_of(max_of(T_SU, T_CE), max_of(T_ACC, T_HLD)),
               max_of(max_of(T_REC, T_STS_MIN), T_CONV_MAX));
    localparam int CNT_W = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] L_SU   = CNT_W'(T_SU - 1);
    localparam logic [CNT_W-1:0] L_CE   = CNT_W'(T_CE - 1);
    localparam logic [CNT_W-1:0] L_ACC  = CNT_W'(T_ACC - 1);
    localparam logic [CNT_W-1:0] L_HLD  = CNT_W'(T_HLD - 1);
    localparam logic [CNT_W-1:0] L_REC  = CNT_W'(T_REC - 1);
    localparam logic [CNT_W-1:0] L_WAIT = CNT_W'(T_CONV_MAX - 1);
    // WAIT counts down from L_WAIT; STS is honoured once
    // T_STS_MIN cycles have elapsed
    localparam logic [CNT_W-1:0] L_CHK  =
        CNT_W'(T_CONV_MAX - 1 - T_STS_MIN);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              op_q, op_d;
    logic [1:0]        addr_q, addr_d;
    pins_t             pins_q, pins_d;
    logic [11:0]       rd_data_q, rd_data_d;
    logic              rd_valid_q, rd_valid_d;
    logic              conv_done_q, conv_done_d;
    logic              err_tmo_q, err_tmo_d;
    logic              sts_s;
    logic              last;

    ad574_sts_sync u_sts_sync (
        .clk     (clk),
        .rstn    (rstn),
        .async_i (ad_sts),
        .sync_o  (sts_s)
    );

    assign last = (cnt_q == '0);

    // next state, request capture and status pulses
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        addr_d      = addr_q;
        rd_data_d   = rd_data_q;
        rd_valid_d  = 1'b0;
        conv_done_d = 1'b0;
        err_tmo_d   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (op_req) begin
                    state_d = S_SETUP;
                    op_d    = op;
                    addr_d  = addr;
                end
            end
            S_SETUP: begin
                if (last) begin
                    state_d = (op_q == OP_CONV) ? S_STROBE
                                                : S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (last) begin
                    state_d    = S_HOLD;
                    rd_data_d  = ad_data;
                    rd_valid_d = 1'b1;
                end
            end
            S_HOLD: begin
                if (last) state_d = S_RECOVER;
            end
            S_STROBE: begin
                if (last) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (cnt_q <= L_CHK && !sts_s) begin
                    state_d     = S_RECOVER;
                    conv_done_d = 1'b1;
                end else if (last) begin
                    state_d   = S_RECOVER;
                    err_tmo_d = 1'b1;
                end
            end
            S_RECOVER: begin
                if (last) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // phase counter: reload on state entry, count down to 0
    always_comb begin
        cnt_d = cnt_q;
        if (state_d != state_q) begin
            unique case (state_d)
                S_SETUP:   cnt_d = L_SU;
                S_ACCESS:  cnt_d = L_ACC;
                S_HOLD:    cnt_d = L_HLD;
                S_STROBE:  cnt_d = L_CE;
                S_WAIT:    cnt_d = L_WAIT;
                S_RECOVER: cnt_d = L_REC;
                default:   cnt_d = '0;
            endcase
        end else if (!last) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // pin levels for the state being entered
    always_comb begin
        pins_d = PINS_IDLE;
        unique case (state_d)
            S_SETUP, S_ACCESS, S_HOLD, S_STROBE: begin
                pins_d.cs_n = 1'b0;
                pins_d.rc   = ~op_d;
                pins_d.a0   = addr_d[ADDR_A0];
                pins_d.b12  = addr_d[ADDR_12_8];
                pins_d.busy = 1'b1;
                pins_d.ce   = (state_d == S_ACCESS) ||
                              (state_d == S_STROBE);
            end
            S_WAIT, S_RECOVER: pins_d.busy = 1'b1;
            default: pins_d = PINS_IDLE;
        endcase
    end

    // state and registered outputs
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            op_q        <= OP_READ;
            addr_q      <= 2'b00;
            pins_q      <= PINS_IDLE;
            rd_data_q   <= 12'h000;
            rd_valid_q  <= 1'b0;
            conv_done_q <= 1'b0;
            err_tmo_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            op_q        <= op_d;
            addr_q      <= addr_d;
            pins_q      <= pins_d;
            rd_data_q   <= rd_data_d;
            rd_valid_q  <= rd_valid_d;
            conv_done_q <= conv_done_d;
            err_tmo_q   <= err_tmo_d;
        end
    end

    assign busy      = pins_q.busy;
    assign ad_cs_n   = pins_q.cs_n;
    assign ad_ce     = pins_q.ce;
    assign ad_rc     = pins_q.rc;
    assign ad_a0     = pins_q.a0;
    assign ad_12_8   = pins_q.b12;
    assign rd_data   = rd_data_q;
    assign rd_valid  = rd_valid_q;
    assign conv_done = conv_done_q;
    assign err_tmo   = err_tmo_q;

endmodule

// File: tb/tb_ad574_bus_ctrl.sv
// Self-checking bench for ad574_bus_ctrl.
// Table vectors, reset corner case and random ops vs a timing model.
module tb_ad574_bus_ctrl;

    localparam int T_SU       = 2;
    localparam int T_CE       = 3;
    localparam int T_ACC      = 4;
    localparam int T_HLD      = 2;
    localparam int T_REC      = 2;
    localparam int T_STS_MIN  = 4;
    localparam int T_CONV_MAX = 4000;
    localparam int W0         = T_SU + T_CE + 1;

    // {busy, cs_n, ce, rc, a0, 12_8, rd_valid, conv_done, err_tmo}
    localparam logic [8:0] IDLE_PINS = 9'b0_1_0_1_0_1_000;

    logic        clk = 1'b0;
    logic        rstn;
    logic        op_req;
    logic        op;
    logic [1:0]  addr;
    logic        busy;
    logic [11:0] rd_data;
    logic        rd_valid;
    logic        conv_done;
    logic        err_tmo;
    logic        ad_cs_n;
    logic        ad_ce;
    logic        ad_rc;
    logic        ad_a0;
    logic        ad_12_8;
    logic        ad_sts;
    logic [11:0] ad_data;

    int n_tests = 0;
    int n_fail  = 0;
    logic [11:0] last_rd;

    ad574_bus_ctrl #(
        .T_SU(T_SU), .T_CE(T_CE), .T_ACC(T_ACC), .T_HLD(T_HLD),
        .T_REC(T_REC), .T_STS_MIN(T_STS_MIN),
        .T_CONV_MAX(T_CONV_MAX)
    ) dut (
        .clk(clk), .rstn(rstn), .op_req(op_req), .op(op),
        .addr(addr), .busy(busy), .rd_data(rd_data),
        .rd_valid(rd_valid), .conv_done(conv_done),
        .err_tmo(err_tmo), .ad_cs_n(ad_cs_n), .ad_ce(ad_ce),
        .ad_rc(ad_rc), .ad_a0(ad_a0), .ad_12_8(ad_12_8),
        .ad_sts(ad_sts), .ad_data(ad_data)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act,
                         input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h",
                     name, act, exp);
        end
    endtask

    function automatic logic [8:0] pins_now();
        return {busy, ad_cs_n, ad_ce, ad_rc, ad_a0, ad_12_8,
                rd_valid, conv_done, err_tmo};
    endfunction

    // STS as driven by the bench in cycle k of an op
    // (k=1 is the first cycle after the accepting edge)
    function automatic bit sts_at(int k, int rise, int len);
        int s;
        s = T_SU + 1 + rise;
        return (k >= s) && (k < s + len);
    endfunction

    // last WAIT cycle on which STS (seen 2 cycles late) is low,
    // or -1 if it never is inside the timeout window
    function automatic int conv_exit(int rise, int len);
        for (int k = W0 + T_STS_MIN; k <= W0 + T_CONV_MAX - 1; k++)
            if (!sts_at(k - 2, rise, len)) return k;
        return -1;
    endfunction

    function automatic bit model_tmo(bit o, int rise, int len);
        return o && (conv_exit(rise, len) < 0);
    endfunction

    function automatic int model_busy(bit o, int rise, int len);
        int e;
        if (!o) return T_SU + T_ACC + T_HLD + T_REC;
        e = conv_exit(rise, len);
        if (e < 0) e = W0 + T_CONV_MAX - 1;
        return e + T_REC;
    endfunction

    function automatic logic [8:0] exp_pins(int k, bit o,
        logic [1:0] a, int n, bit tmo);
        logic sel, cs_n, ce, rc, a0, b12, rv, dn, et;
        if (k < 1 || k > n) return IDLE_PINS;
        rv = 1'b0; dn = 1'b0; et = 1'b0;
        if (!o) begin
            sel = (k <= T_SU + T_ACC + T_HLD);
            ce  = (k > T_SU) && (k <= T_SU + T_ACC);
            rc  = 1'b1;
            rv  = (k == T_SU + T_ACC + 1);
        end else begin
            sel = (k <= T_SU + T_CE);
            ce  = (k > T_SU) && sel;
            rc  = !sel;
            dn  = !tmo && (k == n - T_REC + 1);
            et  = tmo && (k == n - T_REC + 1);
        end
        cs_n = !sel;
        a0   = sel ? a[0] : 1'b0;
        b12  = sel ? a[1] : 1'b1;
        return {1'b1, cs_n, ce, rc, a0, b12, rv, dn, et};
    endfunction

    // issue one op from an idle controller and follow it
    // cycle by cycle; entered and left at posedge+1
    task automatic run_op(input string nm, input bit o,
        input logic [1:0] a, input logic [11:0] d,
        input int rise, input int len, input bit extra,
        input int exp_busy, input int exp_done,
        input int exp_tmo);
        int n, bad_k, busy_c, done_c, tmo_c, rv_c, ce_r;
        bit tmo, prev_ce;
        logic [8:0] p, e, bad_p, bad_e;
        n = model_busy(o, rise, len);
        tmo = model_tmo(o, rise, len);
        bad_k = -1; bad_p = '0; bad_e = '0;
        busy_c = 0; done_c = 0; tmo_c = 0; rv_c = 0; ce_r = 0;
        prev_ce = 1'b0;
        op_req = 1'b1; op = o; addr = a;
        ad_sts = 1'b0; ad_data = ~d;
        for (int k = 0; k <= n + 2; k++) begin
            @(negedge clk);
            p = pins_now();
            e = exp_pins(k, o, a, n, tmo);
            if (p !== e && bad_k < 0) begin
                bad_k = k; bad_p = p; bad_e = e;
            end
            busy_c += int'(busy);
            done_c += int'(conv_done);
            tmo_c  += int'(err_tmo);
            rv_c   += int'(rd_valid);
            if (ad_ce && !prev_ce) ce_r++;
            prev_ce = ad_ce;
            if (!o && k == T_SU + T_ACC + 1)
                check({nm, " rd_data"}, int'(rd_data), int'(d));
            @(posedge clk);
            #1;
            op_req = (extra && k + 1 <= n) ?
                     1'($urandom_range(0, 1)) : 1'b0;
            ad_sts = sts_at(k + 1, rise, len);
            ad_data = (k + 1 == T_SU + T_ACC) ? d : ~d;
        end
        op_req = 1'b0; ad_sts = 1'b0;
        n_tests++;
        if (bad_k >= 0) begin
            n_fail++;
            $display("FAIL %s wave cycle %0d: pins %b expected %b",
                     nm, bad_k, bad_p, bad_e);
        end
        check({nm, " busy_len"}, busy_c, exp_busy);
        check({nm, " conv_done"}, done_c, exp_done);
        check({nm, " err_tmo"}, tmo_c, exp_tmo);
        check({nm, " rd_valid"}, rv_c, o ? 0 : 1);
        check({nm, " ce_pulses"}, ce_r, 1);
        if (o) check({nm, " rd_kept"}, int'(rd_data), int'(last_rd));
        else last_rd = d;
    endtask

    typedef struct {
        string      nm;
        bit         o;
        logic [1:0] a;
        logic [11:0] d;
        int         rise;
        int         len;
        bit         extra;
        int         exp_busy;
        int         exp_done;
        int         exp_tmo;
    } vec_t;

    vec_t vecs[9];

    initial begin
        int rv_c, busy_c;
        rstn = 1'b0; op_req = 1'b0; op = 1'b0; addr = 2'b00;
        ad_sts = 1'b0; ad_data = 12'h000; last_rd = 12'h000;

        repeat (3) @(negedge clk);
        check("reset_pins", int'(pins_now()), int'(IDLE_PINS));
        check("reset_rd_data", int'(rd_data), 0);
        rstn = 1'b1;
        @(posedge clk);
        #1;

        vecs[0] = '{"rd_a5c",  1'b0, 2'b10, 12'hA5C, 0, 0,
                    1'b0, 10, 0, 0};
        vecs[1] = '{"rd_extra", 1'b0, 2'b01, 12'h3C7, 0, 0,
                    1'b1, 10, 0, 0};
        vecs[2] = '{"cv_500",  1'b1, 2'b10, 12'h000, 2, 500,
                    1'b0, 509, 1, 0};
        vecs[3] = '{"cv_nosts", 1'b1, 2'b00, 12'h000, 0, 0,
                    1'b0, 12, 1, 0};
        vecs[4] = '{"cv_edge", 1'b1, 2'b11, 12'h000, 0, 6,
                    1'b1, 13, 1, 0};
        vecs[5] = '{"cv_late", 1'b1, 2'b01, 12'h000, 0, 4000,
                    1'b0, 4007, 1, 0};
        vecs[6] = '{"cv_tmo1", 1'b1, 2'b10, 12'h000, 0, 4001,
                    1'b0, 4007, 0, 1};
        vecs[7] = '{"cv_stuck", 1'b1, 2'b10, 12'h000, 0, 1 << 30,
                    1'b0, 4007, 0, 1};
        vecs[8] = '{"rd_fff",  1'b0, 2'b11, 12'hFFF, 0, 0,
                    1'b0, 10, 0, 0};

        for (int i = 0; i < 9; i++)
            run_op(vecs[i].nm, vecs[i].o, vecs[i].a, vecs[i].d,
                   vecs[i].rise, vecs[i].len, vecs[i].extra,
                   vecs[i].exp_busy, vecs[i].exp_done,
                   vecs[i].exp_tmo);

        // reset while CE is high on a read
        op_req = 1'b1; op = 1'b0; addr = 2'b11; ad_data = 12'h123;
        @(posedge clk);
        #1;
        op_req = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("mid_ce_high", int'(ad_ce), 1);
        rstn = 1'b0;
        #1;
        check("mid_reset_pins", int'(pins_now()), int'(IDLE_PINS));
        @(negedge clk);
        rstn = 1'b1;
        rv_c = 0; busy_c = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            rv_c += int'(rd_valid);
            busy_c += int'(busy);
        end
        check("mid_no_rd_valid", rv_c, 0);
        check("mid_no_busy", busy_c, 0);
        check("mid_rd_data", int'(rd_data), 0);
        last_rd = 12'h000;
        @(posedge clk);
        #1;

        for (int i = 0; i < 25; i++) begin
            bit o;
            int rise, len;
            o = 1'($urandom_range(0, 1));
            rise = int'($urandom_range(0, 4));
            len = int'($urandom_range(0, 40));
            run_op($sformatf("rnd%0d", i), o, 2'($urandom),
                   12'($urandom), rise, len,
                   1'($urandom_range(0, 1)),
                   model_busy(o, rise, len),
                   (o && !model_tmo(o, rise, len)) ? 1 : 0,
                   model_tmo(o, rise, len) ? 1 : 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
